// File: rtl/led_chase_if.sv
// Signal bundle between the board I/O (buttons, switches) and the LED chase controller.
// There is no handshake: inputs are levels or raw buttons, and step_o is the only event strobe (one cycle per position change).
interface led_chase_if;
    logic       run;
    logic [1:0] mode;
    logic       btn_dir;
    logic       btn_speed;
    logic [3:0] led;
    logic       dir_o;
    logic [1:0] speed_o;
    logic       step_o;
    logic [1:0] state_o;

    modport master (
        output run, mode, btn_dir, btn_speed,
        input  led, dir_o, speed_o, step_o, state_o
    );

    modport slave (
        input  run, mode, btn_dir, btn_speed,
        output led, dir_o, speed_o, step_o, state_o
    );
endinterface

// File: rtl/led_chase_ctrl.sv
// Single-clock four-LED chaser: clock-enable prescaler, debounced buttons and an
// IDLE/ROTATE/BOUNCE/MANUAL mode FSM driving a one-hot LED position.
module led_chase_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int PRESC_BASE = 64
) (
    input logic         clk,
    input logic         rst_n,
    led_chase_if.slave  bus
);
    localparam int PW = $clog2(8 * PRESC_BASE);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ROTATE = 2'b01,
        S_BOUNCE = 2'b10,
        S_MANUAL = 2'b11
    } state_t;

    // Index 0 = direction button, index 1 = speed/step button.
    logic [1:0]    sync1, sync2, level, level_d;
    logic [DW-1:0] cnt [2];
    logic          press_dir, press_spd;

    state_t        state_q, state_d;
    logic          running, manual_st, hold;

    logic [1:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic [1:0]    speed_q, speed_d;
    logic [PW-1:0] presc_q, presc_d, period_m1;
    logic [3:0]    led_q;
    logic          step_q;
    logic          tick, spd_evt, mstep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync1   <= {bus.btn_speed, bus.btn_dir};
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEB_CYCLES)) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the rising edge of the debounced level is an event; releases are ignored.
    assign press_dir = level[0] & ~level_d[0];
    assign press_spd = level[1] & ~level_d[1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        if (bus.run) begin
            case (bus.mode)
                2'b00:   state_d = S_ROTATE;
                2'b01:   state_d = S_BOUNCE;
                default: state_d = S_MANUAL;
            endcase
        end
    end

    always_comb begin
        bus.state_o = state_q;
        running     = (state_q == S_ROTATE) || (state_q == S_BOUNCE);
        manual_st   = (state_q == S_MANUAL);
        hold        = (state_d == state_q);
    end

    // Moves are suppressed on a state-change edge, so no step pulse can land in IDLE.
    always_comb begin
        period_m1 = PW'((PRESC_BASE << (3 - int'(speed_q))) - 1);
        tick      = running && hold && (presc_q == period_m1);
        spd_evt   = press_spd && !manual_st;
        mstep     = press_spd && manual_st && hold;
        pos_d     = pos_q;
        dir_d     = dir_q;
        speed_d   = speed_q;

        if (tick && state_q == S_BOUNCE && dir_q && pos_q == 2'd3) begin
            pos_d = 2'd2;
            dir_d = 1'b0;
        end else if (tick && state_q == S_BOUNCE && !dir_q && pos_q == 2'd0) begin
            pos_d = 2'd1;
            dir_d = 1'b1;
        end else if (tick || mstep) begin
            pos_d = dir_q ? pos_q + 2'd1 : pos_q - 2'd1;
        end

        if (press_dir) dir_d   = ~dir_d;
        if (spd_evt)   speed_d = speed_q + 2'd1;

        if (!hold || spd_evt || tick || manual_st) presc_d = '0;
        else if (running)                          presc_d = presc_q + 1'b1;
        else                                       presc_d = presc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= 2'd0;
            dir_q   <= 1'b1;
            speed_q <= 2'd0;
            presc_q <= '0;
            led_q   <= 4'b0001;
            step_q  <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            presc_q <= presc_d;
            led_q   <= 4'b0001 << pos_d;
            step_q  <= (pos_d != pos_q);
        end
    end

    assign bus.led     = led_q;
    assign bus.dir_o   = dir_q;
    assign bus.speed_o = speed_q;
    assign bus.step_o  = step_q;
endmodule
